// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer for a single word-addressed data memory port.
// Each accepted request occupies one ACCESS cycle on the memory port. Its
// response is returned in the following RESP cycle, and RESP can accept the
// next request at the same time.
module data_memory_arbiter #(
   parameter int unsigned ADDR_W     = 14,
   parameter bit          FIXED_PRIO = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   // port 0
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [3:0]        p0_byteena,
   input  logic [31:0]       p0_wdata,
   input  logic              p0_wren,
   output logic              p0_rsp_valid,
   output logic [31:0]       p0_rsp_rdata,
   // port 1
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [3:0]        p1_byteena,
   input  logic [31:0]       p1_wdata,
   input  logic              p1_wren,
   output logic              p1_rsp_valid,
   output logic [31:0]       p1_rsp_rdata,
   // memory port
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteena,
   output logic [31:0]       mem_data,
   output logic              mem_wren,
   input  logic [31:0]       mem_q
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q;
   logic                acc_port_q;
   logic                acc_wren_q;
   logic                accept_c;
   logic                grant_c;
   logic [ADDR_W-1:0]   sel_addr_c;
   logic [BE_W-1:0]     sel_be_c;
   logic [DATA_W-1:0]   sel_wdata_c;
   logic                sel_wren_c;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and arbitration. Requests are only accepted in IDLE or RESP.
   always_comb begin
      state_d      = state_q;
      accept_c     = 1'b0;
      grant_c      = 1'b0;
      p0_req_ready = 1'b0;
      p1_req_ready = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (p0_req_valid || p1_req_valid) begin
               state_d  = ACCESS;
               accept_c = 1'b1;
               if (p0_req_valid && p1_req_valid)
                  grant_c = FIXED_PRIO ? 1'b0 : ~last_grant_q;
               else
                  grant_c = p1_req_valid;
               p0_req_ready = ~grant_c;
               p1_req_ready = grant_c;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Select the request fields of the winning port
   always_comb begin
      sel_addr_c  = grant_c ? p1_addr    : p0_addr;
      sel_be_c    = grant_c ? p1_byteena : p0_byteena;
      sel_wdata_c = grant_c ? p1_wdata   : p0_wdata;
      sel_wren_c  = grant_c ? p1_wren    : p0_wren;
   end

   // Latch the accepted request onto the memory port and return responses.
   // mem_wren is high for the ACCESS cycle only, and only if a lane is enabled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= 1'b1;
         acc_port_q   <= 1'b0;
         acc_wren_q   <= 1'b0;
         mem_address  <= '0;
         mem_byteena  <= '0;
         mem_data     <= '0;
         mem_wren     <= 1'b0;
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         p0_rsp_rdata <= '0;
         p1_rsp_rdata <= '0;
      end else begin
         mem_wren     <= 1'b0;
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         if (accept_c) begin
            last_grant_q <= grant_c;
            acc_port_q   <= grant_c;
            acc_wren_q   <= sel_wren_c;
            mem_address  <= sel_addr_c;
            mem_byteena  <= sel_be_c;
            mem_data     <= sel_wdata_c;
            mem_wren     <= sel_wren_c && (|sel_be_c);
         end
         if (state_q == ACCESS) begin
            if (acc_port_q) begin
               p1_rsp_valid <= 1'b1;
               p1_rsp_rdata <= acc_wren_q ? DATA_W'(0) : mem_q;
            end else begin
               p0_rsp_valid <= 1'b1;
               p0_rsp_rdata <= acc_wren_q ? DATA_W'(0) : mem_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: round-robin instance (g_dut[0]) and
// fixed-priority instance (g_dut[1]) share the request inputs, each with its own memory.
module tb_data_memory_arbiter;

   logic        clock;
   logic        reset_n;
   logic        mem_init;

   logic        p0_req_valid, p1_req_valid;
   logic [7:0]  p0_addr, p1_addr;
   logic [3:0]  p0_byteena, p1_byteena;
   logic [31:0] p0_wdata, p1_wdata;
   logic        p0_wren, p1_wren;

   logic [1:0]  p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, mem_wren;
   logic [31:0] p0_rsp_rdata [2];
   logic [31:0] p1_rsp_rdata [2];
   logic [7:0]  mem_address  [2];
   logic [3:0]  mem_byteena  [2];
   logic [31:0] mem_data     [2];
   logic [31:0] mem_q        [2];
   logic [31:0] mem [2][256];

   int n_cmp = 0;
   int n_err = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      data_memory_arbiter #(.ADDR_W(8), .FIXED_PRIO(1'(g))) u_dut (
         .clock        (clock),
         .reset_n      (reset_n),
         .p0_req_valid (p0_req_valid),
         .p0_req_ready (p0_req_ready[g]),
         .p0_addr      (p0_addr),
         .p0_byteena   (p0_byteena),
         .p0_wdata     (p0_wdata),
         .p0_wren      (p0_wren),
         .p0_rsp_valid (p0_rsp_valid[g]),
         .p0_rsp_rdata (p0_rsp_rdata[g]),
         .p1_req_valid (p1_req_valid),
         .p1_req_ready (p1_req_ready[g]),
         .p1_addr      (p1_addr),
         .p1_byteena   (p1_byteena),
         .p1_wdata     (p1_wdata),
         .p1_wren      (p1_wren),
         .p1_rsp_valid (p1_rsp_valid[g]),
         .p1_rsp_rdata (p1_rsp_rdata[g]),
         .mem_address  (mem_address[g]),
         .mem_byteena  (mem_byteena[g]),
         .mem_data     (mem_data[g]),
         .mem_wren     (mem_wren[g]),
         .mem_q        (mem_q[g])
      );
      assign mem_q[g] = mem[g][mem_address[g]];
   end

   // Memory models: byte-lane writes on the clock edge, combinational read
   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[k][i] <= 32'h0;
            mem[k][8'h10] <= 32'h1234_5678;
            mem[k][8'h30] <= 32'h5A5A_5A5A;
         end else if (mem_wren[k]) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteena[k][b]) mem[k][mem_address[k]][8*b +: 8] <= mem_data[k][8*b +: 8];
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      n_cmp++; if (p0_req_ready[0] !== 1'b0 || p1_req_ready[0] !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b%b want 00", p0_req_ready[0], p1_req_ready[0]); end
      n_cmp++; if (p0_rsp_valid[0] !== 1'b0 || p1_rsp_valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b%b want 00", p0_rsp_valid[0], p1_rsp_valid[0]); end
      n_cmp++; if (p0_rsp_rdata[0] !== 32'h0 || p1_rsp_rdata[0] !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h %h want 0 0", p0_rsp_rdata[0], p1_rsp_rdata[0]); end
      n_cmp++; if (mem_address[0] !== 8'h0 || mem_byteena[0] !== 4'h0 || mem_data[0] !== 32'h0 || mem_wren[0] !== 1'b0) begin n_err++; $display("FAIL reset_mem: got a=%h be=%h d=%h we=%b want all 0", mem_address[0], mem_byteena[0], mem_data[0], mem_wren[0]); end
   endtask

   task automatic test_read();
      p0_req_valid = 1'b1; p0_addr = 8'h10; p0_wren = 1'b0; p0_byteena = 4'hF;
      #1;
      n_cmp++; if (p0_req_ready[0] !== 1'b1 || p1_req_ready[0] !== 1'b0) begin n_err++; $display("FAIL read_ready: got %b%b want 10", p0_req_ready[0], p1_req_ready[0]); end
      tick();
      p0_req_valid = 1'b0;
      #1;
      n_cmp++; if (mem_wren[0] !== 1'b0 || mem_address[0] !== 8'h10) begin n_err++; $display("FAIL read_access: got we=%b a=%h want 0 10", mem_wren[0], mem_address[0]); end
      n_cmp++; if (p0_rsp_valid[0] !== 1'b0) begin n_err++; $display("FAIL read_early_rsp: got %b want 0", p0_rsp_valid[0]); end
      tick();
      n_cmp++; if (p0_rsp_valid[0] !== 1'b1 || p0_rsp_rdata[0] !== 32'h1234_5678 || p1_rsp_valid[0] !== 1'b0) begin n_err++; $display("FAIL read_rsp: got v=%b d=%h v1=%b want 1 12345678 0", p0_rsp_valid[0], p0_rsp_rdata[0], p1_rsp_valid[0]); end
      tick();
      n_cmp++; if (p0_rsp_valid[0] !== 1'b0 || p0_rsp_rdata[0] !== 32'h1234_5678) begin n_err++; $display("FAIL read_hold: got v=%b d=%h want 0 12345678", p0_rsp_valid[0], p0_rsp_rdata[0]); end
   endtask

   task automatic test_write();
      p1_req_valid = 1'b1; p1_addr = 8'h20; p1_wren = 1'b1; p1_byteena = 4'b0011; p1_wdata = 32'hAABB_CCDD;
      #1;
      n_cmp++; if (p1_req_ready[0] !== 1'b1 || p0_req_ready[0] !== 1'b0) begin n_err++; $display("FAIL write_ready: got %b%b want 01", p0_req_ready[0], p1_req_ready[0]); end
      tick();
      p1_req_valid = 1'b0;
      n_cmp++; if (mem_wren[0] !== 1'b1 || mem_byteena[0] !== 4'b0011 || mem_data[0] !== 32'hAABB_CCDD) begin n_err++; $display("FAIL write_access: got we=%b be=%b d=%h want 1 0011 aabbccdd", mem_wren[0], mem_byteena[0], mem_data[0]); end
      tick();
      n_cmp++; if (mem_wren[0] !== 1'b0 || p1_rsp_valid[0] !== 1'b1 || p1_rsp_rdata[0] !== 32'h0) begin n_err++; $display("FAIL write_rsp: got we=%b v=%b d=%h want 0 1 0", mem_wren[0], p1_rsp_valid[0], p1_rsp_rdata[0]); end
      // read back from the RESP cycle (overlapped accept)
      p1_req_valid = 1'b1; p1_wren = 1'b0;
      #1;
      n_cmp++; if (p1_req_ready[0] !== 1'b1) begin n_err++; $display("FAIL write_rb_ready: got %b want 1", p1_req_ready[0]); end
      tick();
      p1_req_valid = 1'b0;
      tick();
      n_cmp++; if (p1_rsp_valid[0] !== 1'b1 || p1_rsp_rdata[0] !== 32'h0000_CCDD) begin n_err++; $display("FAIL write_readback: got v=%b d=%h want 1 0000ccdd", p1_rsp_valid[0], p1_rsp_rdata[0]); end
      tick();
   endtask

   task automatic test_round_robin();
      int rsp0 = 0;
      int rsp1 = 0;
      logic er0, er1, ev0, ev1;
      p0_addr = 8'h10; p0_wren = 1'b0; p1_addr = 8'h20; p1_wren = 1'b0;
      p0_req_valid = 1'b1; p1_req_valid = 1'b1;
      for (int c = 0; c < 18; c++) begin
         #1;
         er0 = (c < 16) && (c % 2 == 0) && ((c / 2) % 2 == 0);
         er1 = (c < 16) && (c % 2 == 0) && ((c / 2) % 2 == 1);
         ev0 = (c >= 2) && (c <= 16) && (c % 2 == 0) && (((c - 2) / 2) % 2 == 0);
         ev1 = (c >= 2) && (c <= 16) && (c % 2 == 0) && (((c - 2) / 2) % 2 == 1);
         n_cmp++; if (p0_req_ready[0] !== er0 || p1_req_ready[0] !== er1) begin n_err++; $display("FAIL rr_grant c=%0d: got %b%b want %b%b", c, p0_req_ready[0], p1_req_ready[0], er0, er1); end
         n_cmp++; if (p0_rsp_valid[0] !== ev0 || p1_rsp_valid[0] !== ev1) begin n_err++; $display("FAIL rr_rsp c=%0d: got %b%b want %b%b", c, p0_rsp_valid[0], p1_rsp_valid[0], ev0, ev1); end
         if (p0_rsp_valid[0]) begin
            rsp0++;
            n_cmp++; if (p0_rsp_rdata[0] !== 32'h1234_5678) begin n_err++; $display("FAIL rr_rdata0 c=%0d: got %h want 12345678", c, p0_rsp_rdata[0]); end
         end
         if (p1_rsp_valid[0]) begin
            rsp1++;
            n_cmp++; if (p1_rsp_rdata[0] !== 32'h0000_CCDD) begin n_err++; $display("FAIL rr_rdata1 c=%0d: got %h want 0000ccdd", c, p1_rsp_rdata[0]); end
         end
         tick();
         if (c == 14) begin p0_req_valid = 1'b0; p1_req_valid = 1'b0; end
      end
      n_cmp++; if (rsp0 != 4 || rsp1 != 4) begin n_err++; $display("FAIL rr_count: got %0d/%0d want 4/4", rsp0, rsp1); end
   endtask

   task automatic test_fixed_prio();
      p0_addr = 8'h10; p0_wren = 1'b0; p1_addr = 8'h20; p1_wren = 1'b0;
      p0_req_valid = 1'b1; p1_req_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_cmp++; if (p0_req_ready[1] !== (c % 2 == 0) || p1_req_ready[1] !== 1'b0) begin n_err++; $display("FAIL fp_grant c=%0d: got %b%b want %b0", c, p0_req_ready[1], p1_req_ready[1], (c % 2 == 0)); end
         tick();
      end
      p0_req_valid = 1'b0;
      #1;
      n_cmp++; if (p1_req_ready[1] !== 1'b1 || p0_req_ready[1] !== 1'b0) begin n_err++; $display("FAIL fp_p1_grant: got %b%b want 01", p0_req_ready[1], p1_req_ready[1]); end
      tick();
      p1_req_valid = 1'b0;
      tick();
      n_cmp++; if (p1_rsp_valid[1] !== 1'b1 || p1_rsp_rdata[1] !== 32'h0000_CCDD) begin n_err++; $display("FAIL fp_p1_rsp: got v=%b d=%h want 1 0000ccdd", p1_rsp_valid[1], p1_rsp_rdata[1]); end
      tick();
   endtask

   task automatic test_zero_byteena();
      p0_req_valid = 1'b1; p0_addr = 8'h10; p0_wren = 1'b1; p0_byteena = 4'b0000; p0_wdata = 32'hFFFF_FFFF;
      tick();
      p0_req_valid = 1'b0;
      n_cmp++; if (mem_wren[0] !== 1'b0) begin n_err++; $display("FAIL be0_wren: got %b want 0", mem_wren[0]); end
      tick();
      n_cmp++; if (p0_rsp_valid[0] !== 1'b1 || p0_rsp_rdata[0] !== 32'h0) begin n_err++; $display("FAIL be0_rsp: got v=%b d=%h want 1 0", p0_rsp_valid[0], p0_rsp_rdata[0]); end
      n_cmp++; if (mem[0][8'h10] !== 32'h1234_5678) begin n_err++; $display("FAIL be0_mem: got %h want 12345678", mem[0][8'h10]); end
      tick();
   endtask

   task automatic test_reset_in_access();
      p1_req_valid = 1'b1; p1_addr = 8'h30; p1_wren = 1'b1; p1_byteena = 4'hF; p1_wdata = 32'hDEAD_BEEF;
      tick();
      p1_req_valid = 1'b0;
      n_cmp++; if (mem_wren[0] !== 1'b1) begin n_err++; $display("FAIL rst_pre_wren: got %b want 1", mem_wren[0]); end
      #1 reset_n = 1'b0;
      #1;
      n_cmp++; if (mem_wren[0] !== 1'b0 || mem_address[0] !== 8'h0) begin n_err++; $display("FAIL rst_wren_drop: got we=%b a=%h want 0 00", mem_wren[0], mem_address[0]); end
      tick();
      n_cmp++; if (p1_rsp_valid[0] !== 1'b0 || mem[0][8'h30] !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL rst_abort: got v=%b mem=%h want 0 5a5a5a5a", p1_rsp_valid[0], mem[0][8'h30]); end
      tick();
      #3 reset_n = 1'b1;
      p0_addr = 8'h10; p0_wren = 1'b0; p1_addr = 8'h20; p1_wren = 1'b0;
      p0_req_valid = 1'b1; p1_req_valid = 1'b1;
      #1;
      n_cmp++; if (p0_req_ready[0] !== 1'b1 || p1_req_ready[0] !== 1'b0) begin n_err++; $display("FAIL rst_first_tie: got %b%b want 10", p0_req_ready[0], p1_req_ready[0]); end
      tick();
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      tick();
      n_cmp++; if (p0_rsp_valid[0] !== 1'b1 || p0_rsp_rdata[0] !== 32'h1234_5678) begin n_err++; $display("FAIL rst_after_rsp: got v=%b d=%h want 1 12345678", p0_rsp_valid[0], p0_rsp_rdata[0]); end
      tick();
   endtask

   initial begin
      reset_n = 1'b0; mem_init = 1'b1;
      p0_req_valid = 1'b0; p0_addr = '0; p0_byteena = '0; p0_wdata = '0; p0_wren = 1'b0;
      p1_req_valid = 1'b0; p1_addr = '0; p1_byteena = '0; p1_wdata = '0; p1_wren = 1'b0;
      tick();
      tick();
      test_reset();
      mem_init = 1'b0;
      reset_n  = 1'b1;
      tick();
      test_read();
      test_write();
      test_round_robin();
      test_fixed_prio();
      test_zero_byteena();
      test_reset_in_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
